// File: rtl/id_decode_stage.sv
// RV32 decode stage: control/ALU-op/immediate decode into the ID/EX register, 1-cycle latency.
// Valid/ready both sides; in_ready = !out_valid || out_ready, so a held entry stalls fetch.
module id_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic [1:0]      out_aluop,
  output logic [3:0]      out_funct,
  output logic            out_regwrite,
  output logic            out_memread,
  output logic            out_memwrite,
  output logic            out_memtoreg,
  output logic            out_alusrc,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [1:0]      aluop;
    logic [3:0]      funct;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            alusrc;
    logic            branch;
    logic            jump;
    logic            illegal;
  } dec_t;

  dec_t dec_d, dec_q;
  logic valid_d, valid_q;
  logic accept;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};
  // Shift-immediates carry only the shamt; instr[30] already travels in funct.
  assign imm_sh = {27'b0, in_instr[24:20]};

  always_comb begin
    dec_d          = '0;
    dec_d.pc       = in_pc;
    dec_d.rs1      = in_instr[19:15];
    dec_d.rs2      = in_instr[24:20];
    dec_d.rd       = in_instr[11:7];
    dec_d.funct    = {1'b0, f3};
    unique case (opcode)
      OP_R: begin
        dec_d.regwrite = 1'b1;
        dec_d.aluop    = 2'b10;
        dec_d.funct    = {in_instr[30], f3};
      end
      OP_IALU: begin
        dec_d.regwrite = 1'b1;
        dec_d.alusrc   = 1'b1;
        dec_d.aluop    = 2'b10;
        if (f3 == 3'b101) dec_d.funct = {in_instr[30], f3};
        dec_d.imm      = (f3 == 3'b001 || f3 == 3'b101) ? imm_sh : imm_i;
      end
      OP_LOAD: begin
        dec_d.regwrite = 1'b1;
        dec_d.memread  = 1'b1;
        dec_d.memtoreg = 1'b1;
        dec_d.alusrc   = 1'b1;
        dec_d.imm      = imm_i;
      end
      OP_STORE: begin
        dec_d.memwrite = 1'b1;
        dec_d.alusrc   = 1'b1;
        dec_d.imm      = imm_s;
      end
      OP_BRANCH: begin
        dec_d.branch   = 1'b1;
        dec_d.aluop    = 2'b01;
        dec_d.imm      = imm_b;
      end
      OP_LUI: begin
        dec_d.regwrite = 1'b1;
        dec_d.alusrc   = 1'b1;
        dec_d.aluop    = 2'b11;
        dec_d.imm      = imm_u;
      end
      OP_AUIPC: begin
        dec_d.regwrite = 1'b1;
        dec_d.alusrc   = 1'b1;
        dec_d.imm      = imm_u;
      end
      OP_JAL: begin
        dec_d.regwrite = 1'b1;
        dec_d.jump     = 1'b1;
        dec_d.imm      = imm_j;
      end
      OP_JALR: begin
        dec_d.regwrite = 1'b1;
        dec_d.jump     = 1'b1;
        dec_d.alusrc   = 1'b1;
        dec_d.imm      = imm_i;
      end
      default: dec_d.illegal = 1'b1;
    endcase
  end

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      if (accept) dec_q <= dec_d;
    end
  end

  assign out_valid    = valid_q;
  assign out_pc       = dec_q.pc;
  assign out_rs1      = dec_q.rs1;
  assign out_rs2      = dec_q.rs2;
  assign out_rd       = dec_q.rd;
  assign out_imm      = dec_q.imm;
  assign out_aluop    = dec_q.aluop;
  assign out_funct    = dec_q.funct;
  assign out_regwrite = dec_q.regwrite;
  assign out_memread  = dec_q.memread;
  assign out_memwrite = dec_q.memwrite;
  assign out_memtoreg = dec_q.memtoreg;
  assign out_alusrc   = dec_q.alusrc;
  assign out_branch   = dec_q.branch;
  assign out_jump     = dec_q.jump;
  assign out_illegal  = dec_q.illegal;

endmodule

// File: tb/tb_id_decode_stage.sv
// Directed bench for id_decode_stage: decode vectors, hold/stream, flush and async reset.
module tb_id_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [1:0]  out_aluop;
  logic [3:0]  out_funct;
  logic        out_regwrite, out_memread, out_memwrite, out_memtoreg;
  logic        out_alusrc, out_branch, out_jump, out_illegal;
  logic [7:0]  ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_aluop(out_aluop), .out_funct(out_funct),
    .out_regwrite(out_regwrite), .out_memread(out_memread), .out_memwrite(out_memwrite),
    .out_memtoreg(out_memtoreg), .out_alusrc(out_alusrc), .out_branch(out_branch),
    .out_jump(out_jump), .out_illegal(out_illegal)
  );

  // {regwrite, memread, memwrite, memtoreg, alusrc, branch, jump, illegal}
  assign ctrl = {out_regwrite, out_memread, out_memwrite, out_memtoreg,
                 out_alusrc, out_branch, out_jump, out_illegal};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b0;
    #3;
    chk("rst valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst ctrl", {24'b0, ctrl}, 32'h0);
    chk("rst aluop", {30'b0, out_aluop}, 32'd0);
    chk("rst funct", {28'b0, out_funct}, 32'd0);
    chk("rst imm", out_imm, 32'h0);
    chk("rst pc", out_pc, 32'h0);
    chk("rst rd", {27'b0, out_rd}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    send(32'h002081B3, 32'h100);                       // add x3,x1,x2
    chk("add valid", {31'b0, out_valid}, 32'd1);
    chk("add ctrl", {24'b0, ctrl}, 32'b1000_0000);
    chk("add aluop", {30'b0, out_aluop}, 32'd2);
    chk("add funct", {28'b0, out_funct}, 32'd0);
    chk("add rs1", {27'b0, out_rs1}, 32'd1);
    chk("add rs2", {27'b0, out_rs2}, 32'd2);
    chk("add rd", {27'b0, out_rd}, 32'd3);
    chk("add pc", out_pc, 32'h100);

    send(32'h407302B3, 32'h104);                       // sub x5,x6,x7
    chk("sub funct", {28'b0, out_funct}, 32'b1000);
    chk("sub rd", {27'b0, out_rd}, 32'd5);

    send(32'h4030D093, 32'h108);                       // srai x1,x1,3
    chk("srai funct", {28'b0, out_funct}, 32'b1101);
    chk("srai ctrl", {24'b0, ctrl}, 32'b1000_1000);
    chk("srai imm", out_imm, 32'd3);

    send(32'h00309093, 32'h10C);                       // slli x1,x1,3
    chk("slli funct", {28'b0, out_funct}, 32'b0001);
    chk("slli imm", out_imm, 32'd3);

    send(32'hFFC12083, 32'h110);                       // lw x1,-4(x2)
    chk("lw ctrl", {24'b0, ctrl}, 32'b1101_1000);
    chk("lw aluop", {30'b0, out_aluop}, 32'd0);
    chk("lw imm", out_imm, 32'hFFFF_FFFC);

    send(32'h00112423, 32'h114);                       // sw x1,8(x2)
    chk("sw ctrl", {24'b0, ctrl}, 32'b0010_1000);
    chk("sw imm", out_imm, 32'd8);

    send(32'hFE208CE3, 32'h118);                       // beq x1,x2,-8
    chk("beq ctrl", {24'b0, ctrl}, 32'b0000_0100);
    chk("beq aluop", {30'b0, out_aluop}, 32'd1);
    chk("beq imm", out_imm, 32'hFFFF_FFF8);

    send(32'h123450B7, 32'h11C);                       // lui x1,0x12345
    chk("lui ctrl", {24'b0, ctrl}, 32'b1000_1000);
    chk("lui aluop", {30'b0, out_aluop}, 32'd3);
    chk("lui imm", out_imm, 32'h1234_5000);

    send(32'h008000EF, 32'h120);                       // jal x1,8
    chk("jal ctrl", {24'b0, ctrl}, 32'b1000_0010);
    chk("jal aluop", {30'b0, out_aluop}, 32'd0);
    chk("jal imm", out_imm, 32'd8);

    send(32'hFFFFFFFF, 32'h124);
    chk("ill valid", {31'b0, out_valid}, 32'd1);
    chk("ill ctrl", {24'b0, ctrl}, 32'b0000_0001);

    // Drain: valid drops, data fields keep their last values.
    tick();
    chk("drain valid", {31'b0, out_valid}, 32'd0);
    chk("drain pc kept", out_pc, 32'h124);

    // Accept one entry then stall EX for 3 cycles with fetch still presenting.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h200);
    in_valid = 1'b1; in_instr = 32'h407302B3; in_pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      chk("hold in_ready", {31'b0, in_ready}, 32'd0);
      chk("hold valid", {31'b0, out_valid}, 32'd1);
      chk("hold pc", out_pc, 32'h200);
      chk("hold rd", {27'b0, out_rd}, 32'd3);
      tick();
    end

    // Release: four instructions stream back-to-back.
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      in_pc    = 32'h204 + 32'(4 * k);
      tick();
      chk("stream valid", {31'b0, out_valid}, 32'd1);
      chk("stream pc", out_pc, 32'h204 + 32'(4 * k));
    end

    // Flush with accept + consume in the same cycle.
    in_valid = 1'b1; in_instr = 32'h00309093; in_pc = 32'h300; flush = 1'b1;
    chk("flush in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush valid", {31'b0, out_valid}, 32'd0);

    // Async reset while an entry is held.
    out_ready = 1'b0;
    send(32'h00112423, 32'h400);
    chk("pre-rst valid", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst valid", {31'b0, out_valid}, 32'd0);
    chk("async rst pc", out_pc, 32'h0);
    chk("async rst in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    send(32'h002081B3, 32'h500);
    chk("post-rst valid", {31'b0, out_valid}, 32'd1);
    chk("post-rst pc", out_pc, 32'h500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
